// File: rtl/iter_shift_unit.sv
// iter_shift_unit: multi-cycle shift/rotate/bit-reverse unit with START/BUSY/DONE handshake
module iter_shift_unit #(
    parameter  int WIDTH = 8,
    parameter  int STEP  = 1,
    localparam int SHW   = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [2:0]       MODE,
    input  logic [WIDTH-1:0] DATA,
    input  logic [SHW-1:0]   SHAMT,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZERO,
    output logic             BUSY,
    output logic             DONE
);
    localparam int LW = $clog2(WIDTH);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] FIN   = 2'd2;
    logic [1:0]       state;
    logic [2:0]       mode_q;
    logic [WIDTH-1:0] work, rev, load, sra, ror, rol, shifted;
    logic [SHW-1:0]   count, s, n, lim;
    logic             accept;
    always_comb begin
        rev = '0;
        for (int i = 0; i < WIDTH; i++) rev[i] = DATA[WIDTH-1-i];
    end
    assign lim     = SHAMT > SHW'(WIDTH) ? SHW'(WIDTH) : SHAMT;
    assign n       = MODE < 3'd3 ? lim : MODE < 3'd5 ? SHW'(SHAMT[LW-1:0]) : '0;
    assign load    = MODE == 3'd5 ? rev : DATA;
    assign s       = count < SHW'(STEP) ? count : SHW'(STEP);
    assign sra     = $signed(work) >>> s;
    assign ror     = (work >> s) | (work << (SHW'(WIDTH) - s));
    assign rol     = (work << s) | (work >> (SHW'(WIDTH) - s));
    assign shifted = mode_q == 3'd0 ? work << s :
                     mode_q == 3'd1 ? work >> s :
                     mode_q == 3'd2 ? sra :
                     mode_q == 3'd3 ? ror :
                     mode_q == 3'd4 ? rol : work;
    assign accept  = START && state != SHIFT;
    assign BUSY    = state == SHIFT;
    assign DONE    = state == FIN;
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state  <= IDLE;
            work   <= '0;
            count  <= '0;
            mode_q <= '0;
            RESULT <= '0;
            ZERO   <= 1'b1;
        end else if (accept) begin
            work   <= load;
            count  <= n;
            mode_q <= MODE;
            state  <= n == '0 ? FIN : SHIFT;
            if (n == '0) begin
                RESULT <= load;
                ZERO   <= ~|load;
            end
        end else if (state == SHIFT) begin
            work  <= shifted;
            count <= count - s;
            if (count == s) begin
                RESULT <= shifted;
                ZERO   <= ~|shifted;
                state  <= FIN;
            end
        end else begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_iter_shift_unit.sv
// tb_iter_shift_unit: scoreboard bench for iter_shift_unit at STEP=1 and STEP=4
module tb_iter_shift_unit;
    localparam logic [2:0] SLL = 3'd0, SRL = 3'd1, SRA = 3'd2, ROR = 3'd3, ROL = 3'd4, REV = 3'd5, PASS = 3'd6;
    typedef struct {
        logic [7:0] r;
        int         b;
    } exp_t;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] st, zero, busy, done;
    logic [2:0] mode;
    logic [7:0] data;
    logic [3:0] shamt;
    logic [7:0] res [2];
    exp_t       q [2][$];
    exp_t       e;
    int         bc [2];
    int         checks = 0, failures = 0;
    int         t;
    always #5 clk = ~clk;
    iter_shift_unit #(.WIDTH(8), .STEP(1)) u1 (
        .CLK(clk), .RESET(rst_n), .START(st[0]), .MODE(mode), .DATA(data), .SHAMT(shamt),
        .RESULT(res[0]), .ZERO(zero[0]), .BUSY(busy[0]), .DONE(done[0])
    );
    iter_shift_unit #(.WIDTH(8), .STEP(4)) u4 (
        .CLK(clk), .RESET(rst_n), .START(st[1]), .MODE(mode), .DATA(data), .SHAMT(shamt),
        .RESULT(res[1]), .ZERO(zero[1]), .BUSY(busy[1]), .DONE(done[1])
    );
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (!rst_n) bc[u] = 0;
            else begin
                if (busy[u]) bc[u]++;
                if (done[u]) begin
                    check("done_busy_excl", int'(busy[u]), 0);
                    if (q[u].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done: unit %0d pulsed DONE with result %0h, no request pending", u, res[u]);
                    end else begin
                        e = q[u].pop_front();
                        check("result", int'(res[u]), int'(e.r));
                        check("zero", int'(zero[u]), int'(e.r == 8'h00));
                        check("busy_cycles", bc[u], e.b);
                    end
                    bc[u] = 0;
                end
            end
        end
    end
    task automatic go(input int u, input logic [2:0] m, input logic [7:0] d, input logic [3:0] sh,
                      input logic [7:0] er, input int eb, input bit push);
        st[u] = 1'b1;
        mode  = m;
        data  = d;
        shamt = sh;
        if (push) q[u].push_back('{er, eb});
        @(negedge clk);
        st[u] = 1'b0;
    endtask
    task automatic wait_done(input int u, output int n);
        n = 0;
        while (!done[u] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("done_timeout", n, -1);
    endtask
    task automatic run(input int u, input logic [2:0] m, input logic [7:0] d, input logic [3:0] sh,
                       input logic [7:0] er, input int eb, input bit b2b);
        int n;
        if (!b2b) @(negedge clk);
        go(u, m, d, sh, er, eb, 1'b1);
        wait_done(u, n);
        check("latency", n, eb);
    endtask
    initial begin
        rst_n = 1'b0;
        st    = 2'b01;
        mode  = REV;
        data  = 8'h0B;
        shamt = '0;
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check("rst_result", int'(res[u]), 0);
            check("rst_zero", int'(zero[u]), 1);
            check("rst_busy", int'(busy[u]), 0);
            check("rst_done", int'(done[u]), 0);
        end
        rst_n = 1'b1;
        run(0, SLL, 8'h81, 4'd3, 8'h08, 3, 1'b1);
        run(0, SRA, 8'h90, 4'd2, 8'hE4, 2, 1'b0);
        run(0, SRA, 8'h90, 4'd9, 8'hFF, 8, 1'b0);
        run(0, ROR, 8'h96, 4'd10, 8'hA5, 2, 1'b0);
        run(0, ROL, 8'h96, 4'd3, 8'hB4, 3, 1'b1);
        run(0, REV, 8'h0B, 4'd0, 8'hD0, 0, 1'b0);
        run(0, SLL, 8'h00, 4'd0, 8'h00, 0, 1'b0);
        run(0, PASS, 8'h5A, 4'd3, 8'h5A, 0, 1'b0);
        run(0, ROL, 8'h3C, 4'd8, 8'h3C, 0, 1'b1);
        run(0, SLL, 8'hFF, 4'd8, 8'h00, 8, 1'b0);
        run(0, SRL, 8'hFF, 4'd15, 8'h00, 8, 1'b0);
        run(1, SRL, 8'hF0, 4'd7, 8'h01, 2, 1'b0);
        run(1, SRA, 8'h80, 4'd8, 8'hFF, 2, 1'b0);
        run(1, ROL, 8'h96, 4'd3, 8'hB4, 1, 1'b0);
        @(negedge clk);
        go(0, SLL, 8'h01, 4'd5, 8'h20, 5, 1'b1);
        st[0] = 1'b1;
        mode  = REV;
        data  = 8'hFF;
        shamt = 4'd1;
        @(negedge clk);
        st[0] = 1'b0;
        wait_done(0, t);
        check("ignored_start_latency", t, 4);
        @(negedge clk);
        check("done_one_cycle", int'(done[0]), 0);
        check("idle_after_done", int'(busy[0]), 0);
        check("result_holds", int'(res[0]), 8'h20);
        go(0, SLL, 8'h03, 4'd5, 8'h00, 0, 1'b0);
        @(negedge clk);
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("midop_rst_result", int'(res[0]), 0);
        check("midop_rst_zero", int'(zero[0]), 1);
        check("midop_rst_busy", int'(busy[0]), 0);
        check("midop_rst_done", int'(done[0]), 0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("queues_drained", q[0].size() + q[1].size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
    initial begin
        #100000;
        $display("FAIL global_timeout: simulation reached %0t without finishing", $time);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/iter_shift_unit.md
Name: iter_shift_unit

Overview:
- Multi-cycle, parametrised shift/rotate/bit-reverse unit for the CPU datapath.
- Generalises the fixed 8-bit combinational bit-reverse to any power-of-2 width.
- Adds logical/arithmetic shifts and rotates, processing STEP bit positions per clock.
- Uses a START/BUSY/DONE handshake so the controller can stall the PC while an sll/srl/sra/ror/rol/rev instruction completes.

Parameters:
- WIDTH, 8, data width in bits; must be a power of 2, at least 4.
- STEP, 1, maximum bit positions shifted per SHIFT cycle; must be 1, 2 or 4, and no greater than WIDTH.
- SHW, $clog2(WIDTH)+1, width of SHAMT (localparam, derived; able to express WIDTH).

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-low reset, sampled on the CLK rising edge.
- START  in  1  request; sampled only in IDLE or DONE.
- MODE  in  3  000 SLL, 001 SRL, 010 SRA, 011 ROR, 100 ROL, 101 REV, 110/111 PASS.
- DATA  in  WIDTH  operand; sampled with START.
- SHAMT  in  SHW  shift amount, unsigned; sampled with START.
- RESULT  out  WIDTH  registered result; holds until the next completion.
- ZERO  out  1  registered; 1 when RESULT==0, updated together with RESULT.
- BUSY  out  1  1 in SHIFT state only.
- DONE  out  1  1 for exactly one cycle, in DONE state.

Behaviour:
- Reset (RESET==0 at an edge), from any state including mid-operation: state=IDLE, RESULT=0, ZERO=1, BUSY=0, DONE=0, work/count registers cleared.
- States: IDLE, SHIFT, DONE.
- Effective amount n, computed at accept:
  - SLL/SRL/SRA: n = min(SHAMT, WIDTH).
  - ROR/ROL: n = SHAMT mod WIDTH (low $clog2(WIDTH) bits).
  - REV/PASS: n = 0.
- Accept: START==1 at edge k while in IDLE or DONE:
  - work register loads DATA; REV loads the bit-reversed DATA (work[i]=DATA[WIDTH-1-i]).
  - count=n; MODE is latched.
  - If n==0: RESULT=work value, next state DONE.
  - Else: next state SHIFT.
- SHIFT, each edge: s=min(STEP,count); work shifted by s per the latched mode; count-=s. When count reaches 0, RESULT/ZERO load the final value at that same edge and the next state is DONE.
- Fill rules:
  - SLL/SRL fill with 0.
  - SRA fills with the original MSB.
  - Rotates wrap bits around.
  - n==WIDTH yields all-zeros for SLL/SRL and all-sign for SRA.
- Latency: DONE is high in the cycle after edge k+ceil(n/STEP). BUSY is high for exactly ceil(n/STEP) cycles.
- DONE state lasts one cycle. Next state is SHIFT or DONE if START is accepted there (back-to-back), otherwise IDLE.
- START in SHIFT is ignored; DATA/SHAMT/MODE changes in SHIFT have no effect.
- DONE and BUSY are never high together.
- RESULT changes only at completion or reset.

Test Plan:
- RESET=0 for 2 edges, START=1 held -> RESULT=8'h00, ZERO=1, BUSY=0, DONE=0. After release, START is accepted on the next edge.
- SLL, DATA=8'h81, SHAMT=3 -> BUSY for 3 cycles, then DONE one cycle, RESULT=8'h08.
- SRA, DATA=8'h90, SHAMT=2 -> RESULT=8'hE4 after 2 BUSY cycles. SRA, DATA=8'h90, SHAMT=9 -> n=8, 8 BUSY cycles, RESULT=8'hFF.
- ROR, DATA=8'h96, SHAMT=10 -> n=2, RESULT=8'hA5. ROL, DATA=8'h96, SHAMT=3 -> RESULT=8'hB4, issued with START asserted in the preceding DONE cycle (back-to-back accepted).
- REV, DATA=8'h0B -> no BUSY cycles, DONE in the cycle after the accept edge, RESULT=8'hD0, ZERO=0. SLL, SHAMT=0, DATA=8'h00 -> same timing, RESULT=8'h00, ZERO=1.
- Two runs:
  - STEP=4, SRL, DATA=8'hF0, SHAMT=7 -> 2 BUSY cycles, RESULT=8'h01.
  - STEP=1, SLL, SHAMT=5, with START pulsed again during BUSY -> ignored. RESET=0 at the 3rd SHIFT edge -> IDLE, RESULT=0, no DONE pulse.
